// File: rtl/prog_loader.sv
// prog_loader: boot-time writer for the instruction memory.
// Accepts a framed byte stream (CNT_LO, CNT_HI, N x {LO, HI}, CSUM) over a
// valid/ready handshake. Each LO/HI pair is packed into one W-bit word and
// written to consecutive addresses starting at 0. A trailing XOR checksum
// is verified, and the CPU is held in reset until a load completes cleanly.
//
// Ports:
//   clk, reset         system clock; asynchronous active-high reset
//   in_valid, in_data  byte source (in_data valid while in_valid is high)
//   in_ready           loader accepts a byte this cycle
//   wr_en/addr/data    instruction-memory write port (one-cycle strobe)
//   cpu_reset          holds the CPU in reset until the load is done
//   load_done          load finished with a matching checksum (sticky)
//   err                format or checksum error (sticky)
module prog_loader #(
  parameter int unsigned D = 10,
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         cpu_reset,
  output logic         load_done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_INS_LO,
    S_INS_HI,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     cnt_lo_q, cnt_lo_d;
  logic [D-1:0]   last_q, last_d;
  logic [D-1:0]   idx_q, idx_d;
  logic [7:0]     lo_q, lo_d;
  logic [7:0]     csum_q, csum_d;
  logic           in_ready_q, in_ready_d;
  logic           wr_en_q, wr_en_d;
  logic [D-1:0]   wr_addr_q, wr_addr_d;
  logic [W-1:0]   wr_data_q, wr_data_d;
  logic           cpu_reset_q, cpu_reset_d;
  logic           load_done_q, load_done_d;
  logic           err_q, err_d;
  logic           xfer;

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_reset = cpu_reset_q;
  assign load_done = load_done_q;
  assign err       = err_q;

  // Byte moves only when the registered ready is high, so in_ready is
  // exactly the "accepting" indication seen by the source this cycle.
  assign xfer = in_valid && in_ready_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_lo_d  = cnt_lo_q;
    last_d    = last_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (xfer) begin
      case (state_q)
        S_CNT_LO: begin
          cnt_lo_d = in_data;
          csum_d   = csum_q ^ in_data;
          state_d  = S_CNT_HI;
        end
        S_CNT_HI: begin
          // Only the low D bits of the 16-bit count are meaningful.
          last_d  = D'({in_data, cnt_lo_q});
          idx_d   = '0;
          csum_d  = csum_q ^ in_data;
          state_d = S_INS_LO;
        end
        S_INS_LO: begin
          lo_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = S_INS_HI;
        end
        S_INS_HI: begin
          if (in_data[7:1] != 7'd0) begin
            state_d = S_ERR;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = W'({in_data[0], lo_q});
            csum_d    = csum_q ^ in_data;
            // Compare before incrementing so N = 2^D never wraps the index.
            if (idx_q == last_q) begin
              state_d = S_CSUM;
            end else begin
              idx_d   = idx_q + D'(1);
              state_d = S_INS_LO;
            end
          end
        end
        S_CSUM: begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end
        default: ;
      endcase
    end

    // Status outputs follow the next state so they change on the same edge.
    in_ready_d  = (state_d != S_DONE) && (state_d != S_ERR);
    cpu_reset_d = (state_d != S_DONE);
    load_done_d = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_CNT_LO;
      cnt_lo_q    <= '0;
      last_q      <= '0;
      idx_q       <= '0;
      lo_q        <= '0;
      csum_q      <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_lo_q    <= cnt_lo_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      csum_q      <= csum_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
    end
  end

endmodule
